shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Sequencer that loads a word serially into an external shift register, then drains it back into dout.
// Optional loopback compare (output err) is enabled by defining SHIFT_SEQUENCER_CHECK_EN.
module shift_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic             sr_so,
    output logic             sr_clr,
    output logic             sr_mode,
    output logic             sr_si,
    output logic             busy,
    output logic             done,
`ifdef SHIFT_SEQUENCER_CHECK_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_din;
    logic             r_dir;

    logic [CW-1:0]    w_k;
    logic [IW-1:0]    w_si_idx;
    logic             w_si_bit;
    logic [IW-1:0]    w_st_idx;
    logic [WIDTH-1:0] w_dout_next;

    // Next serial bit to present and the dout slot the current drain cycle fills.
    always_comb begin
        w_k      = (r_state == S_CLR) ? {CW{1'b0}} : CW'(r_cnt + CW'(1));
        w_si_idx = IW'(r_dir ? (CNT_LAST - w_k) : w_k);
        if (w_k < CW'(WIDTH)) begin
            w_si_bit = r_din[w_si_idx];
        end else begin
            w_si_bit = 1'b0;
        end
        w_st_idx    = IW'(r_dir ? (CNT_LAST - r_cnt) : r_cnt);
        w_dout_next = dout;
        w_dout_next[w_st_idx] = sr_so;
    end

    // Control FSM; every output is registered so it lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_din   <= {WIDTH{1'b0}};
            r_dir   <= 1'b0;
            sr_clr  <= 1'b0;
            sr_mode <= 1'b0;
            sr_si   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= {WIDTH{1'b0}};
`ifdef SHIFT_SEQUENCER_CHECK_EN
            err     <= 1'b0;
`endif
        end else if (abort && (r_state inside {S_CLR, S_SHIFT, S_DRAIN})) begin
            // Abort wins over phase completion and discards the partial word.
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            sr_clr  <= 1'b0;
            sr_mode <= 1'b0;
            sr_si   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= {CW{1'b0}};
                    done  <= 1'b0;
                    sr_si <= 1'b0;
                    if (start) begin
                        r_state <= S_CLR;
                        r_din   <= din;
                        r_dir   <= dir;
                        sr_clr  <= 1'b1;
                        sr_mode <= dir;
                        busy    <= 1'b1;
                        dout    <= {WIDTH{1'b0}};
`ifdef SHIFT_SEQUENCER_CHECK_EN
                        err     <= 1'b0;
`endif
                    end else begin
                        sr_clr  <= 1'b0;
                        sr_mode <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_state <= S_SHIFT;
                    r_cnt   <= {CW{1'b0}};
                    sr_clr  <= 1'b0;
                    sr_si   <= w_si_bit;
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= {CW{1'b0}};
                        sr_si   <= 1'b0;
                    end else begin
                        r_cnt <= CW'(r_cnt + CW'(1));
                        sr_si <= w_si_bit;
                    end
                end
                S_DRAIN: begin
                    dout <= w_dout_next;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= {CW{1'b0}};
                        busy    <= 1'b0;
                        done    <= 1'b1;
`ifdef SHIFT_SEQUENCER_CHECK_EN
                        err     <= (w_dout_next != r_din);
`endif
                    end else begin
                        r_cnt <= CW'(r_cnt + CW'(1));
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= {CW{1'b0}};
                    done    <= 1'b0;
                    sr_mode <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= {CW{1'b0}};
                    sr_clr  <= 1'b0;
                    sr_mode <= 1'b0;
                    sr_si   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
